// File: rtl/keypad_pkg.sv
// Shared types, key map and column-drive helpers for the 4x4 keypad scanner and its
// downstream debouncer.
package keypad_pkg;

    localparam int unsigned KEY_W = 4;

    typedef logic [1:0] col_idx_t;
    typedef logic [1:0] row_idx_t;

    typedef enum logic {
        SCAN,
        HOLD
    } scan_state_t;

    // Indexed KEY_MAP[row][col].
    localparam logic [KEY_W-1:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic [3:0] col_drive(col_idx_t col);
        logic [3:0] onehot;
        onehot = 4'b0001 << col;
        return ~onehot;
    endfunction

    // Row pattern seen when exactly the given row is pulled low.
    function automatic logic [3:0] row_pattern(row_idx_t row);
        logic [3:0] onehot;
        onehot = 4'b0001 << row;
        return ~onehot;
    endfunction

endpackage

// File: rtl/row_synchronizer.sv
// Two-flop synchronizer for the asynchronous keypad row lines; resets to all rows idle (high).
// Only instantiated when KEYPAD_SCANNER_SYNC_EN is defined.
module row_synchronizer (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_async,
    output logic [3:0] row_sync
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= row_async;
            sync_q <= meta_q;
        end
    end

    assign row_sync = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks an active-low column, detects a single pressed key and freezes on it.
// Define KEYPAD_SCANNER_SYNC_EN to add a two-flop synchronizer on row_in.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 48000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_pressed
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 2) begin : g_bad_settle
        $error("keypad_scanner: SETTLE_CYCLES must be at least 2");
    end

    logic [3:0] row_s;

`ifdef KEYPAD_SCANNER_SYNC_EN
    row_synchronizer u_row_sync (
        .clk       (clk),
        .reset     (reset),
        .row_async (row_in),
        .row_sync  (row_s)
    );
`else
    assign row_s = row_in;
`endif

    scan_state_t      state_q, state_d;
    col_idx_t         col_q, col_d;
    row_idx_t         row_idx_q, row_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic             pressed_q, pressed_d;

    // Single-low decode; zero or several low rows are treated as no key.
    logic     single_low;
    row_idx_t hit_row;

    always_comb begin
        single_low = 1'b0;
        hit_row    = 2'd0;
        case (row_s)
            4'b1110: begin single_low = 1'b1; hit_row = 2'd0; end
            4'b1101: begin single_low = 1'b1; hit_row = 2'd1; end
            4'b1011: begin single_low = 1'b1; hit_row = 2'd2; end
            4'b0111: begin single_low = 1'b1; hit_row = 2'd3; end
            default: begin single_low = 1'b0; hit_row = 2'd0; end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_idx_d = row_idx_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        pressed_d = pressed_q;

        unique case (state_q)
            SCAN: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (single_low) begin
                        state_d   = HOLD;
                        row_idx_d = hit_row;
                        code_d    = KEY_MAP[hit_row][col_q];
                        pressed_d = 1'b1;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                // Release and a second key in the same column both break the pattern.
                if (row_s != row_pattern(row_idx_q)) begin
                    state_d   = SCAN;
                    pressed_d = 1'b0;
                    cnt_d     = '0;
                    col_d     = col_q + 2'd1;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SCAN;
            col_q     <= 2'd0;
            row_idx_q <= 2'd0;
            cnt_q     <= '0;
            code_q    <= '0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_idx_q <= row_idx_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            pressed_q <= pressed_d;
        end
    end

    assign col_out     = col_drive(col_q);
    assign key_code    = code_q;
    assign key_pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SETTLE_CYCLES=4 and a behavioural 4x4 key matrix.
// Sync latency follows KEYPAD_SCANNER_SYNC_EN so either build can be exercised.
module tb_keypad_scanner;

`ifdef KEYPAD_SCANNER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_pressed;

    // Bit r*4+c set means the key at row r, column c is held down.
    logic [15:0] keys;

    int n_checks;
    int n_errors;

    keypad_scanner #(
        .SETTLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_code    (key_code),
        .key_pressed (key_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    int bad;
    int changes;
    logic [3:0] prev_col;

    initial begin
        n_checks = 0;
        n_errors = 0;
        keys     = 16'h0000;
        reset    = 1'b1;

        // Reset with idle rows, then free-running column walk.
        step(2);
        check_eq("rst_col", col_out, 4'b1110);
        check_eq("rst_kp", key_pressed, 0);
        check_eq("rst_code", key_code, 4'h0);
        reset = 1'b0;
        step(3);
        check_eq("walk_c0", col_out, 4'b1110);
        step(1);
        check_eq("walk_c1", col_out, 4'b1101);
        step(4);
        check_eq("walk_c2", col_out, 4'b1011);
        step(4);
        check_eq("walk_c3", col_out, 4'b0111);
        step(4);
        check_eq("walk_wrap", col_out, 4'b1110);

        // Press "6" (r1,c2): col2 driven from edge 8, sampled at edge 12.
        keys = 16'h0040;
        step(11);
        check_eq("k6_pre", key_pressed, 0);
        step(1);
        check_eq("k6_kp", key_pressed, 1);
        check_eq("k6_code", key_code, 4'h6);
        check_eq("k6_col", col_out, 4'b1011);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (col_out !== 4'b1011 || key_pressed !== 1'b1) bad++;
        end
        check_eq("k6_hold50", bad, 0);

        // Release: key_pressed falls SYNC_LAT+1 edges later and the column advances.
        keys = 16'h0000;
        step(SYNC_LAT);
        check_eq("rel_still", key_pressed, 1);
        step(1);
        check_eq("rel_kp", key_pressed, 0);
        check_eq("rel_col", col_out, 4'b0111);
        check_eq("rel_code_kept", key_code, 4'h6);

        // Multi-press "1"+"4" in col0: ignored, scanning continues every 4 cycles.
        keys = 16'h0011;
        bad = 0;
        changes = 0;
        prev_col = col_out;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (key_pressed !== 1'b0) bad++;
            if (col_out !== prev_col) changes++;
            prev_col = col_out;
        end
        check_eq("multi_kp", bad, 0);
        check_eq("multi_steps", changes, 10);
        check_eq("multi_col", col_out, 4'b1101);

        // Same-column second key: hold "1", then add "4".
        keys = 16'h0001;
        step(15);
        check_eq("k1_pre", key_pressed, 0);
        step(1);
        check_eq("k1_kp", key_pressed, 1);
        check_eq("k1_code", key_code, 4'h1);
        check_eq("k1_col", col_out, 4'b1110);
        keys = 16'h0011;
        step(SYNC_LAT);
        check_eq("k14_still", key_pressed, 1);
        step(1);
        check_eq("k14_kp", key_pressed, 0);
        check_eq("k14_col", col_out, 4'b1101);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (key_pressed !== 1'b0) bad++;
        end
        check_eq("k14_nodet", bad, 0);
        keys = 16'h0001;
        step(7);
        check_eq("k1_again_pre", key_pressed, 0);
        step(1);
        check_eq("k1_again_kp", key_pressed, 1);
        check_eq("k1_again_code", key_code, 4'h1);
        keys = 16'h0000;
        step(SYNC_LAT + 1);
        check_eq("k1_rel_kp", key_pressed, 0);
        check_eq("k1_rel_col", col_out, 4'b1101);

        // Hold "D" (r3,c3), then pulse reset mid-hold.
        keys = 16'h8000;
        step(12);
        check_eq("kd_kp", key_pressed, 1);
        check_eq("kd_code", key_code, 4'hD);
        check_eq("kd_col", col_out, 4'b0111);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_eq("mrst_kp", key_pressed, 0);
        check_eq("mrst_col", col_out, 4'b1110);
        check_eq("mrst_code", key_code, 4'h0);
        step(15);
        check_eq("kd_re_pre", key_pressed, 0);
        step(1);
        check_eq("kd_re_kp", key_pressed, 1);
        check_eq("kd_re_code", key_code, 4'hD);
        check_eq("kd_re_col", col_out, 4'b0111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
